// File: rtl/hash_lookup_if.sv
// hash_lookup_if: request/response, hash-unit and table-RAM signals of the
// hash_lookup stage. slave = lookup stage view, master = surrounding view.
interface hash_lookup_if #(
  parameter int IDX_W = 8
);
  logic             req_valid_i;
  logic             req_ready_o;
  logic [63:0]      key_i;
  logic             hash_start_o;
  logic [63:0]      hash_key_o;
  logic             hash_ready_i;
  logic [31:0]      hash_val_i;
  logic             mem_rd_o;
  logic [IDX_W-1:0] mem_addr_o;
  logic [96:0]      mem_data_i;
  logic             resp_valid_o;
  logic             resp_ready_i;
  logic             resp_hit_o;
  logic [31:0]      resp_val_o;

  modport slave (
    input  req_valid_i, key_i, hash_ready_i, hash_val_i, mem_data_i, resp_ready_i,
    output req_ready_o, hash_start_o, hash_key_o, mem_rd_o, mem_addr_o,
           resp_valid_o, resp_hit_o, resp_val_o
  );

  modport master (
    output req_valid_i, key_i, hash_ready_i, hash_val_i, mem_data_i, resp_ready_i,
    input  req_ready_o, hash_start_o, hash_key_o, mem_rd_o, mem_addr_o,
           resp_valid_o, resp_hit_o, resp_val_o
  );
endinterface

// File: rtl/hash_lookup.sv
// hash_lookup: exact-match lookup behind the byte-fold hash unit.
// Key -> hash -> bucket read from a synchronous table RAM -> key compare.
// Optional linear probing is enabled by defining HASH_LOOKUP_PROBE_EN.
// All strobes are registered from the next state so they line up with state_q
// and all clear together on reset.
module hash_lookup #(
  parameter int IDX_W     = 8,
  parameter int MAX_PROBE = 4
) (
  input  logic           clk,
  input  logic           rst,
  hash_lookup_if.slave   bus
);
  localparam logic [31:0] ZERO_WORD = 32'h0;

  typedef enum logic [2:0] {
    IDLE, HASH_START, HASH_WAIT, READ, MEM_WAIT, COMPARE, RESP
  } state_t;

  state_t           state_q, state_d;
  logic [63:0]      key_q, key_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [96:0]      entry_q, entry_d;
  logic             hit_q, hit_d;
  logic [31:0]      val_q, val_d;
  logic             req_ready_q, hash_start_q, mem_rd_q, resp_valid_q;
  logic             key_match;

`ifdef HASH_LOOKUP_PROBE_EN
  localparam int PW = $clog2(MAX_PROBE + 1);
  logic [PW-1:0] probe_q, probe_d;
`endif

  assign key_match = entry_q[96] && (entry_q[95:32] == key_q);

  // Next-state, datapath capture and probe decision
  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    idx_d   = idx_q;
    entry_d = entry_q;
    hit_d   = hit_q;
    val_d   = val_q;
`ifdef HASH_LOOKUP_PROBE_EN
    probe_d = probe_q;
`endif
    case (state_q)
      IDLE: begin
        if (req_ready_q && bus.req_valid_i) begin
          key_d   = bus.key_i;
          state_d = HASH_START;
        end
      end
      HASH_START: state_d = HASH_WAIT;
      HASH_WAIT: begin
        if (bus.hash_ready_i) begin
          idx_d   = bus.hash_val_i[IDX_W-1:0];
`ifdef HASH_LOOKUP_PROBE_EN
          probe_d = '0;
`endif
          state_d = READ;
        end
      end
      READ: begin
`ifdef HASH_LOOKUP_PROBE_EN
        probe_d = probe_q + 1'b1;
`endif
        state_d = MEM_WAIT;
      end
      MEM_WAIT: begin
        // RAM output is only guaranteed this cycle; keep a copy for COMPARE
        entry_d = bus.mem_data_i;
        state_d = COMPARE;
      end
      COMPARE: begin
        hit_d   = key_match;
        val_d   = key_match ? entry_q[31:0] : ZERO_WORD;
        state_d = RESP;
`ifdef HASH_LOOKUP_PROBE_EN
        // Occupied bucket holding another key: try the next one (wraps)
        if (entry_q[96] && !key_match && (probe_q < PW'(MAX_PROBE))) begin
          hit_d   = hit_q;
          val_d   = val_q;
          idx_d   = idx_q + 1'b1;
          state_d = READ;
        end
`endif
      end
      RESP: if (bus.resp_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, datapath and registered strobes
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      key_q        <= '0;
      idx_q        <= '0;
      entry_q      <= '0;
      hit_q        <= 1'b0;
      val_q        <= ZERO_WORD;
      req_ready_q  <= 1'b0;
      hash_start_q <= 1'b0;
      mem_rd_q     <= 1'b0;
      resp_valid_q <= 1'b0;
`ifdef HASH_LOOKUP_PROBE_EN
      probe_q      <= '0;
`endif
    end else begin
      state_q      <= state_d;
      key_q        <= key_d;
      idx_q        <= idx_d;
      entry_q      <= entry_d;
      hit_q        <= hit_d;
      val_q        <= val_d;
      req_ready_q  <= (state_d == IDLE);
      hash_start_q <= (state_d == HASH_START);
      mem_rd_q     <= (state_d == READ);
      resp_valid_q <= (state_d == RESP);
`ifdef HASH_LOOKUP_PROBE_EN
      probe_q      <= probe_d;
`endif
    end
  end

  assign bus.req_ready_o  = req_ready_q;
  assign bus.hash_start_o = hash_start_q;
  assign bus.hash_key_o   = key_q;
  assign bus.mem_rd_o     = mem_rd_q;
  assign bus.mem_addr_o   = idx_q;
  assign bus.resp_valid_o = resp_valid_q;
  assign bus.resp_hit_o   = hit_q;
  assign bus.resp_val_o   = val_q;
endmodule
